reg_write_sequencer: RTL
========================

Name: reg_write_sequencer

Overview:
- Master for the register file write port (reg_write_en / reg_write_dest / reg_write_data); the only block allowed to drive it.
- Merges two writeback sources (A: ALU, B: load unit) through valid/ready handshakes using round-robin arbitration.
- Provides a bulk-init engine that fills every register with one value, one register per clock.
- All write-port outputs are registered.

Parameters:
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 4, register address width
NUM_REGS, 16, registers swept by init; must equal 2**ADDR_WIDTH
ZERO_REG_EN, 0, 1 = register 0 is hardwired zero: writebacks to it are dropped and init writes 0 to it

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
init_start  input  1  request bulk init; sampled only in IDLE
init_value  input  DATA_WIDTH  fill value; captured on the init_start edge
init_busy  output  1  high while state = INIT
init_done  output  1  one-cycle pulse coincident with the last init write
wb_a_valid  input  1  source A request
wb_a_dest  input  ADDR_WIDTH  source A destination register
wb_a_data  input  DATA_WIDTH  source A data
wb_a_ready  output  1  source A accepted this cycle
wb_b_valid  input  1  source B request
wb_b_dest  input  ADDR_WIDTH  source B destination register
wb_b_data  input  DATA_WIDTH  source B data
wb_b_ready  output  1  source B accepted this cycle
reg_write_en  output  1  register file write enable, registered
reg_write_dest  output  ADDR_WIDTH  register file write address, registered
reg_write_data  output  DATA_WIDTH  register file write data, registered

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE; init counter = 0; captured init value = 0.
  - last_grant = B, so A wins the first tie.
  - All outputs 0.
  - Reset wins over everything, including mid-init: the sweep is abandoned, no init_done pulse, and no write occurs on the reset edge.
- States: IDLE, INIT.
- IDLE:
  - If init_start = 1: both readies are 0. Next edge: state = INIT, counter = 0, init_value captured. No write is issued on that edge.
  - Otherwise, combinational grant:
    - Only A valid -> wb_a_ready = 1.
    - Only B valid -> wb_b_ready = 1.
    - Both valid -> grant goes to the source not equal to last_grant.
    - At most one ready is high in any cycle. Ready may depend on valid.
  - A handshake (valid & ready) at edge N:
    - reg_write_en = 1 after edge N, with the granted dest/data, for exactly one cycle.
    - last_grant updates to the granted source.
    - Latency from handshake to write = 1 cycle. Sustained throughput = 1 write per cycle.
  - ZERO_REG_EN = 1 and accepted dest = 0: handshake completes, last_grant updates, reg_write_en stays 0.
  - No handshake -> reg_write_en = 0. reg_write_dest and reg_write_data hold their previous values.
- INIT:
  - Both readies are 0. init_start is ignored. init_busy = 1.
  - Each edge: reg_write_en = 1, reg_write_dest = counter, reg_write_data = captured value (0 when counter = 0 and ZERO_REG_EN = 1); then counter increments.
  - When counter = NUM_REGS-1: that write is performed, init_done = 1 for that cycle, state returns to IDLE. The counter does not wrap into a second sweep.
  - Exactly NUM_REGS consecutive write cycles, dest 0..NUM_REGS-1 in ascending order.
  - A handshake can occur in the cycle after the last init write, so reg_write_en may stay high without a gap.
- last_grant is unchanged by init.
- Pending valids are never dropped; sources hold valid/dest/data until ready.

Test Plan:
1. Reset, then A valid dest=3 data=16'hBEEF for 1 cycle -> wb_a_ready=1 that cycle; next cycle reg_write_en=1, dest=3, data=BEEF; following cycle reg_write_en=0.
2. A and B both valid continuously (A: dest 1, data 1111; B: dest 2, data 2222) for 4 cycles after reset -> grants alternate A,B,A,B; writes appear one cycle later in the same order, back-to-back with reg_write_en held high.
3. init_start=1 with init_value=16'h00A5, A valid throughout -> init_busy high 16 cycles; writes dest 0..15 all 00A5; init_done pulses with dest=15; wb_a_ready=0 for the whole sweep, then A is accepted in the first IDLE cycle.
4. ZERO_REG_EN=1: B writes dest=0 data=FFFF -> wb_b_ready=1, no reg_write_en pulse. Then run init with value 1234 -> reg 0 is written 0000, regs 1..15 are written 1234.
5. rst asserted while the init counter = 7 -> next cycle all outputs 0, state IDLE, init_busy=0, no init_done. A new init_start then sweeps again from dest 0.
6. Reference model with a 16×16 shadow array under random A/B/init traffic -> every reg_write_en cycle matches the model's expected dest/data, and no accepted transaction is lost or duplicated.

Source files
------------

// File: rtl/reg_write_sequencer_if.sv
// Writeback-source handshakes and register-file write port, bundled as one bus.
// The master side is the sequencer; the slave side is the sources plus register file.
interface reg_write_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wb_a_valid;
    logic [ADDR_WIDTH-1:0] wb_a_dest;
    logic [DATA_WIDTH-1:0] wb_a_data;
    logic                  wb_a_ready;

    logic                  wb_b_valid;
    logic [ADDR_WIDTH-1:0] wb_b_dest;
    logic [DATA_WIDTH-1:0] wb_b_data;
    logic                  wb_b_ready;

    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] reg_write_dest;
    logic [DATA_WIDTH-1:0] reg_write_data;

    modport master (
        input  wb_a_valid, wb_a_dest, wb_a_data,
        input  wb_b_valid, wb_b_dest, wb_b_data,
        output wb_a_ready, wb_b_ready,
        output reg_write_en, reg_write_dest, reg_write_data
    );

    modport slave (
        output wb_a_valid, wb_a_dest, wb_a_data,
        output wb_b_valid, wb_b_dest, wb_b_data,
        input  wb_a_ready, wb_b_ready,
        input  reg_write_en, reg_write_dest, reg_write_data
    );
endinterface

// File: rtl/reg_write_sequencer.sv
// Register-file write-port master: round-robin merge of ALU (A) and load (B)
// writebacks, plus a bulk-init engine that fills every register one per clock.
module reg_write_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    input  logic [DATA_WIDTH-1:0] init_value,
    output logic                  init_busy,
    output logic                  init_done,
    reg_write_sequencer_if.master wb
);
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
    localparam bit                    ZERO_REG = (ZERO_REG_EN != 0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] val_q,    val_d;
    logic                  last_b_q, last_b_d;
    logic                  en_q,     en_d;
    logic [ADDR_WIDTH-1:0] dest_q,   dest_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic                  done_q,   done_d;

    logic                  grant_a;
    logic                  grant_b;
    logic [ADDR_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0] sel_data;

    // State and write-port registers; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            val_q    <= '0;
            last_b_q <= 1'b1;
            en_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            last_b_q <= last_b_d;
            en_q     <= en_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    // Arbitration, init sweep sequencing and next write-port values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        last_b_d = last_b_q;
        en_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        done_d   = 1'b0;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        sel_dest = wb.wb_a_dest;
        sel_data = wb.wb_a_data;

        case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    val_d   = init_value;
                end else begin
                    // On a tie, the source that did not win last time goes first.
                    if (wb.wb_a_valid && (!wb.wb_b_valid || last_b_q)) begin
                        grant_a = 1'b1;
                    end else if (wb.wb_b_valid) begin
                        grant_b = 1'b1;
                    end

                    if (grant_b) begin
                        sel_dest = wb.wb_b_dest;
                        sel_data = wb.wb_b_data;
                    end

                    if (grant_a || grant_b) begin
                        last_b_d = grant_b;
                        // A hardwired-zero register swallows the write but still completes the handshake.
                        if (!(ZERO_REG && (sel_dest == '0))) begin
                            en_d   = 1'b1;
                            dest_d = sel_dest;
                            data_d = sel_data;
                        end
                    end
                end
            end

            INIT: begin
                en_d   = 1'b1;
                dest_d = cnt_q;
                data_d = (ZERO_REG && (cnt_q == '0)) ? '0 : val_q;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_REG) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Readies are combinational; a reset cycle never accepts anything.
    assign wb.wb_a_ready     = grant_a & ~rst;
    assign wb.wb_b_ready     = grant_b & ~rst;
    assign wb.reg_write_en   = en_q;
    assign wb.reg_write_dest = dest_q;
    assign wb.reg_write_data = data_q;
    assign init_busy         = (state_q == INIT);
    assign init_done         = done_q;

endmodule
